as1802_mem_arbiter: RTL
=======================

AS1802_MEM_ARBITER -- requirements
Module: as1802_mem_arbiter

Interface
REQ-001 SHALL have parameter PROTECT_BASE, default 16'hF000, lowest address of the write-protected window.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port cpu_addr, input, 8, the CPU's multiplexed address byte.
REQ-005 SHALL have port cpu_tpa, input, 1, high-byte strobe.
REQ-006 SHALL have ports cpu_mrd and cpu_mwr, input, 1 each, active-low read and write strobes.
REQ-007 SHALL have port cpu_dout, input, 8, CPU write data.
REQ-008 SHALL have port cpu_din, output, 8, CPU read data.
REQ-009 SHALL have ports dma_req, input, 1, and dma_we, input, 1.
REQ-010 SHALL have ports dma_addr, input, 16, and dma_wdata, input, 8.
REQ-011 SHALL have ports dma_ack, output, 1, and dma_rdata, output, 8.
REQ-012 SHALL have ports mem_addr, output, 16; mem_wdata, output, 8; mem_re, output, 1; mem_we, output, 1; mem_rdata, input, 8 (asynchronous-read RAM).
REQ-013 SHALL have port prot_err, output, 1, sticky protection violation flag.

Function
REQ-014 hi_latch SHALL capture cpu_addr on each clock where cpu_tpa=1, and SHALL hold otherwise.
REQ-015 hi_hold SHALL be set for exactly the one cycle after a cpu_tpa=1 cycle; in that cycle cpu_addr still carries the high byte.
REQ-016 The CPU owns the memory port in any cycle with cpu_mrd=0 or cpu_mwr=0 (combinational, absolute priority).
REQ-017 While the CPU owns the port: mem_addr={hi_latch,cpu_addr}; mem_wdata=cpu_dout; mem_re=~cpu_mrd & ~cpu_tpa & ~hi_hold; mem_we=~cpu_mwr; cpu_din=mem_rdata (zero added latency).
REQ-018 The DMA FSM SHALL have states D_IDLE, D_ACC and D_DONE.
REQ-019 D_IDLE to D_ACC SHALL occur when dma_req=1, cpu_mrd=1, cpu_mwr=1 and cpu_tpa=0; on that transition dma_addr, dma_we and dma_wdata SHALL be registered.
REQ-020 In D_ACC with the CPU owning the port, the DMA access SHALL be aborted for that cycle (no mem strobe from DMA, no ack) and the FSM SHALL stay in D_ACC (retry).
REQ-021 In D_ACC with the CPU idle, the port SHALL be driven from the registered DMA values for one cycle (mem_re=~we, mem_we=we), mem_rdata SHALL be registered into dma_rdata on a read, and the FSM SHALL go to D_DONE.
REQ-022 In D_DONE, dma_ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to D_IDLE; dma_req SHALL be resampled only in D_IDLE.
REQ-023 When neither the CPU nor DMA drives the port: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 cpu_din SHALL be mem_rdata whenever cpu_mrd=0, and 8'h00 otherwise.
REQ-025 A dma_req drop while in D_ACC SHALL NOT cancel the access; the access SHALL complete and be acknowledged.

Reset
REQ-026 Reset SHALL set hi_latch=8'hFF, matching the CPU's initial high-address assumption.
REQ-027 Reset SHALL set hi_hold=0, FSM=D_IDLE, dma_ack=0, dma_rdata=8'h00 and prot_err=0.
REQ-028 Reset asserted mid-access SHALL abort the access immediately with no ack.

Configuration
REQ-029 With AS1802_ARB_WPROT_EN defined, a write with {hi_latch,cpu_addr} >= PROTECT_BASE (CPU) or dma_addr >= PROTECT_BASE (DMA) SHALL force mem_we=0 and set prot_err; a DMA write so blocked SHALL still be acked.
REQ-030 Without AS1802_ARB_WPROT_EN, all writes SHALL pass through, and prot_err SHALL be tied to 0.

Verification
REQ-031 Read with high-byte strobe: tpa cycle with addr=8'h12, then hold cycle, then addr=8'h34, mrd=0, RAM[1234]=5A -> mem_addr=1234, cpu_din=5A; mem_re=0 during the tpa and hold cycles.
REQ-032 Read without high-byte strobe after reset: mrd=0, addr=8'h00 -> mem_addr=FF00.
REQ-033 DMA write on idle bus: dma_req, dma_we=1, addr 0100, data A5 -> RAM[0100]=A5; dma_ack high 2 cycles after grant.
REQ-034 Collision: DMA in D_ACC while the CPU drops mwr -> the CPU write lands, the DMA retries after mwr rises, and exactly one ack is issued.
REQ-035 With AS1802_ARB_WPROT_EN defined: CPU write to F000 -> RAM unchanged and prot_err=1 until reset; a write to EFFF succeeds.
REQ-036 Assert rst during D_ACC -> dma_ack is never pulsed and the FSM is in D_IDLE.

Source files
------------

// File: rtl/as1802_mem_arbiter.sv
// as1802_mem_arbiter
//   Shares one asynchronous-read RAM port between an 1802-style CPU bus and a
//   single-beat DMA requester. The CPU has absolute, combinational priority.
//   A DMA access is captured on grant and is retried until it finds a cycle
//   in which the CPU does not hold a strobe. It is then acknowledged with a
//   one-cycle dma_ack pulse.
//
//   Optional feature: define AS1802_ARB_WPROT_EN to write-protect addresses
//   at and above PROTECT_BASE. A blocked write sets the sticky prot_err flag.
//   A blocked DMA write is still acknowledged.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cpu_addr, cpu_tpa multiplexed address byte; tpa marks the high byte
//   cpu_mrd, cpu_mwr  active-low read / write strobes
//   cpu_dout, cpu_din CPU write data / CPU read data
//   dma_req, dma_we, dma_addr, dma_wdata   DMA request and its payload
//   dma_ack, dma_rdata                     completion pulse, read data
//   mem_addr, mem_wdata, mem_re, mem_we, mem_rdata   RAM port
//   prot_err          sticky write-protection violation flag
module as1802_mem_arbiter #(
    parameter logic [15:0] PROTECT_BASE = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cpu_addr,
    input  logic        cpu_tpa,
    input  logic        cpu_mrd,
    input  logic        cpu_mwr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        prot_err
);

`ifdef AS1802_ARB_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {D_IDLE, D_ACC, D_DONE} dma_state_t;

    dma_state_t  state, state_nxt;
    logic [7:0]  hi_latch;
    logic        hi_hold;
    logic [15:0] dma_addr_q;
    logic        dma_we_q;
    logic [7:0]  dma_wdata_q;

    logic        cpu_own;
    logic [15:0] cpu_full_addr;
    logic        cpu_wr_blk;
    logic        dma_wr_blk;
    logic        grant;
    logic        dma_go;

    assign cpu_own       = ~cpu_mrd | ~cpu_mwr;
    assign cpu_full_addr = {hi_latch, cpu_addr};
    assign cpu_wr_blk    = WPROT_EN && (cpu_full_addr >= PROTECT_BASE);
    assign dma_wr_blk    = WPROT_EN && (dma_addr_q >= PROTECT_BASE);

    // cpu_din is gated so an idle CPU bus never sees stale RAM data
    assign cpu_din = cpu_mrd ? 8'h00 : mem_rdata;

    // Control state: high-address latch, hold flag, DMA FSM, DMA read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_latch  <= 8'hFF;
            hi_hold   <= 1'b0;
            state     <= D_IDLE;
            dma_rdata <= 8'h00;
        end else begin
            if (cpu_tpa)
                hi_latch <= cpu_addr;
            // cpu_addr still shows the high byte in the cycle after tpa
            hi_hold <= cpu_tpa;
            state   <= state_nxt;
            if (dma_go && !dma_we_q)
                dma_rdata <= mem_rdata;
        end
    end

    // DMA payload is captured once at grant; dma_req may drop afterwards
    always_ff @(posedge clk) begin
        if (grant) begin
            dma_addr_q  <= dma_addr;
            dma_we_q    <= dma_we;
            dma_wdata_q <= dma_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        dma_ack   = 1'b0;
        grant     = 1'b0;
        dma_go    = 1'b0;

        if (cpu_own) begin
            mem_addr  = cpu_full_addr;
            mem_wdata = cpu_dout;
            mem_re    = ~cpu_mrd & ~cpu_tpa & ~hi_hold;
            mem_we    = ~cpu_mwr & ~cpu_wr_blk;
        end

        case (state)
            D_IDLE: begin
                if (dma_req && cpu_mrd && cpu_mwr && !cpu_tpa) begin
                    grant     = 1'b1;
                    state_nxt = D_ACC;
                end
            end
            D_ACC: begin
                // a CPU strobe pre-empts the beat; stay here and retry
                if (!cpu_own) begin
                    dma_go    = 1'b1;
                    mem_addr  = dma_addr_q;
                    mem_wdata = dma_wdata_q;
                    mem_re    = ~dma_we_q;
                    mem_we    = dma_we_q & ~dma_wr_blk;
                    state_nxt = D_DONE;
                end
            end
            D_DONE: begin
                dma_ack   = 1'b1;
                state_nxt = D_IDLE;
            end
            default: state_nxt = D_IDLE;
        endcase
    end

`ifdef AS1802_ARB_WPROT_EN
    logic prot_set;
    assign prot_set = (cpu_own & ~cpu_mwr & cpu_wr_blk) |
                      (dma_go & dma_we_q & dma_wr_blk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prot_err <= 1'b0;
        else if (prot_set)
            prot_err <= 1'b1;
    end
`else
    assign prot_err = 1'b0;
`endif

endmodule
